// File: rtl/ptc_mfb2axi_pkg.sv
// Shared constants and TUSER layout helpers for the MFB to AXI-Stream request converter.
// TUSER is packed as {eop_ptr[R-1..0], is_eop[R-1:0], is_sop[R-1:0]}.
package ptc_mfb2axi_pkg;

  localparam int ERR_SOF_POS = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_W       = 2;

  // Occupancy of the output register slice: encoding equals the entry count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic int dw_count(input int data_width);
    return data_width / 32;
  endfunction

  function automatic int ptr_w(input int data_width);
    return $clog2(data_width / 32);
  endfunction

  function automatic int sof_pos_w(input int reg_size);
    return (reg_size > 1) ? $clog2(reg_size) : 1;
  endfunction

  function automatic int sop_off();
    return 0;
  endfunction

  function automatic int eop_off(input int regions);
    return regions;
  endfunction

  function automatic int ptr_off(input int regions);
    return 2 * regions;
  endfunction

  function automatic int tuser_w(input int regions, input int data_width);
    return 2 * regions + regions * ptr_w(data_width);
  endfunction

endpackage

// File: rtl/ptc_mfb2axi_axis_if.sv
// AXI-Stream request bus toward the PCIe hard IP; a word transfers when tvalid && tready.
interface ptc_mfb2axi_axis_if
  import ptc_mfb2axi_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 12
);
  localparam int KEEP_W = dw_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic [KEEP_W-1:0]     tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/ptc_mfb2axi_mfb_if.sv
// MFB stream bus. A beat transfers on a clock edge where src_rdy && dst_rdy are both high;
// the source holds every field stable while src_rdy is high and dst_rdy is low.
interface ptc_mfb2axi_mfb_if
  import ptc_mfb2axi_pkg::*;
#(
  parameter int REGIONS    = 2,
  parameter int REG_SIZE   = 1,
  parameter int BLOCK_SIZE = 8,
  parameter int ITEM_WIDTH = 32
);
  localparam int DATA_W    = REGIONS * REG_SIZE * BLOCK_SIZE * ITEM_WIDTH;
  localparam int SOF_POS_W = REGIONS * sof_pos_w(REG_SIZE);
  localparam int EOF_POS_W = REGIONS * $clog2(REG_SIZE * BLOCK_SIZE);

  logic [DATA_W-1:0]    data;
  logic [SOF_POS_W-1:0] sof_pos;
  logic [EOF_POS_W-1:0] eof_pos;
  logic [REGIONS-1:0]   sof;
  logic [REGIONS-1:0]   eof;
  logic                 src_rdy;
  logic                 dst_rdy;

  modport master (output data, sof_pos, eof_pos, sof, eof, src_rdy, input dst_rdy);
  modport slave  (input data, sof_pos, eof_pos, sof, eof, src_rdy, output dst_rdy);
endinterface

// File: rtl/ptc_mfb2axi_skid.sv
// Two-entry valid/ready register slice: registered outputs and registered in_ready,
// full throughput under backpressure, strict FIFO order.
module ptc_mfb2axi_skid
  import ptc_mfb2axi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output skid_state_t           state
);
  skid_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic                  push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = (state_q != SKID_EMPTY) && out_ready;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = slot0_q;
  assign state     = state_q;

  // slot0 is always the head; slot1 only holds the word that arrived while head stalled.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      SKID_EMPTY: if (push) begin
        slot0_d = in_data;
        state_d = SKID_ONE;
      end
      SKID_ONE: begin
        if (push && pop) begin
          slot0_d = in_data;
        end else if (push) begin
          slot1_d = in_data;
          state_d = SKID_FULL;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: if (pop) begin
        slot0_d = slot1_q;
        state_d = SKID_ONE;
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SKID_EMPTY;
      slot0_q  <= '0;
      slot1_q  <= '0;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      in_ready <= (state_d != SKID_FULL);
    end
  end
endmodule

// File: rtl/ptc_pcie_mfb2axi.sv
// Request-path converter: MFB SOF/EOF framing to AXI-Stream is_sop/is_eop/eop_ptr, TKEEP, TLAST,
// registered behind a two-entry slice.
module ptc_pcie_mfb2axi
  import ptc_mfb2axi_pkg::*;
#(
  parameter string DEVICE         = "ULTRASCALE",
  parameter int    MFB_REGIONS    = 2,
  parameter int    MFB_REG_SIZE   = 1,
  parameter int    MFB_BLOCK_SIZE = 8,
  parameter int    MFB_ITEM_WIDTH = 32,
  parameter int    AXI_DATA_WIDTH = 512
) (
  input  logic                    CLK,
  input  logic                    RESET,
  ptc_mfb2axi_mfb_if.slave        rx_mfb,
  ptc_mfb2axi_axis_if.master      tx_axi,
  output logic [ERR_W-1:0]        ERR,
  output skid_state_t             dbg_skid_state
);
  localparam int R     = MFB_REGIONS;
  localparam int DW    = dw_count(AXI_DATA_WIDTH);
  localparam int RDW   = DW / R;
  localparam int PW    = ptr_w(AXI_DATA_WIDTH);
  localparam int SPW   = sof_pos_w(MFB_REG_SIZE);
  localparam int EPW   = $clog2(MFB_REG_SIZE * MFB_BLOCK_SIZE);
  localparam int UW    = tuser_w(R, AXI_DATA_WIDTH);
  localparam int PKT_W = AXI_DATA_WIDTH + UW + DW + 1;

  if (AXI_DATA_WIDTH != MFB_REGIONS * MFB_REG_SIZE * MFB_BLOCK_SIZE * MFB_ITEM_WIDTH
      || (MFB_BLOCK_SIZE * MFB_ITEM_WIDTH) % 32 != 0
      || !(R == 1 || R == 2 || R == 4) || DEVICE == "") begin : g_cfg_err
    $error("ptc_pcie_mfb2axi: unsupported parameter combination");
  end

  logic             in_pkt;
  logic             pkt_open, any_eof, err_sof_pos, err_framing;
  logic [DW-1:0]    keep;
  logic [R*PW-1:0]  eop_ptr;
  logic [UW-1:0]    user;
  logic             accept, skid_in_ready;
  logic [PKT_W-1:0] skid_out;
  int               ptr_v;

  assign accept         = rx_mfb.src_rdy && skid_in_ready;
  assign rx_mfb.dst_rdy = skid_in_ready;

  // Walk regions in order carrying the open-packet flag; a region is live if a packet
  // is open on entry or starts in it, and its tail beyond an EOF is dropped.
  always_comb begin
    pkt_open    = in_pkt;
    keep        = '0;
    eop_ptr     = '0;
    any_eof     = 1'b0;
    err_sof_pos = 1'b0;
    err_framing = 1'b0;
    ptr_v       = 0;
    for (int r = 0; r < R; r++) begin
      ptr_v = r * RDW + (int'(rx_mfb.eof_pos[r*EPW +: EPW]) * MFB_ITEM_WIDTH) / 32;
      eop_ptr[r*PW +: PW] = PW'(ptr_v);
      if (rx_mfb.sof[r] && rx_mfb.sof_pos[r*SPW +: SPW] != '0) err_sof_pos = 1'b1;
      if (rx_mfb.sof[r] && pkt_open) err_framing = 1'b1;
      if (rx_mfb.eof[r] && !pkt_open && !rx_mfb.sof[r]) err_framing = 1'b1;
      if (pkt_open || rx_mfb.sof[r]) begin
        for (int d = 0; d < RDW; d++) begin
          if (!rx_mfb.eof[r] || (r * RDW + d) <= ptr_v) keep[r*RDW+d] = 1'b1;
        end
      end
      if (rx_mfb.eof[r]) any_eof = 1'b1;
      pkt_open = (pkt_open || rx_mfb.sof[r]) && !rx_mfb.eof[r];
    end
  end

  always_comb begin
    user                     = '0;
    user[sop_off() +: R]     = rx_mfb.sof;
    user[eop_off(R) +: R]    = rx_mfb.eof;
    user[ptr_off(R) +: R*PW] = eop_ptr;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_pkt <= 1'b0;
      ERR    <= '0;
    end else if (accept) begin
      in_pkt           <= pkt_open;
      ERR[ERR_SOF_POS] <= ERR[ERR_SOF_POS] | err_sof_pos;
      ERR[ERR_FRAMING] <= ERR[ERR_FRAMING] | err_framing;
    end
  end

  ptc_mfb2axi_skid #(.DATA_WIDTH(PKT_W)) u_skid (
    .clk       (CLK),
    .rst       (RESET),
    .in_data   ({rx_mfb.data, user, keep, !pkt_open && any_eof}),
    .in_valid  (rx_mfb.src_rdy),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out),
    .out_valid (tx_axi.tvalid),
    .out_ready (tx_axi.tready),
    .state     (dbg_skid_state)
  );

  assign {tx_axi.tdata, tx_axi.tuser, tx_axi.tkeep, tx_axi.tlast} = skid_out;
endmodule

// File: tb/tb_ptc_pcie_mfb2axi.sv
// Directed bench for ptc_pcie_mfb2axi with R=2, 512-bit words (16 dwords, 8 per region).
module tb_ptc_pcie_mfb2axi;
  import ptc_mfb2axi_pkg::*;

  localparam int DWIDTH = 512;
  localparam int DW     = 16;
  localparam int UW     = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  err;
  skid_state_t dbg_state;
  int          n_cmp = 0;
  int          n_err = 0;

  ptc_mfb2axi_mfb_if #(.REGIONS(2), .REG_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32)) rx_mfb ();
  ptc_mfb2axi_axis_if #(.DATA_WIDTH(DWIDTH), .USER_WIDTH(UW)) tx_axi ();

  ptc_pcie_mfb2axi #(
    .DEVICE("ULTRASCALE"), .MFB_REGIONS(2), .MFB_REG_SIZE(1), .MFB_BLOCK_SIZE(8),
    .MFB_ITEM_WIDTH(32), .AXI_DATA_WIDTH(DWIDTH)
  ) dut (
    .CLK(clk), .RESET(rst), .rx_mfb(rx_mfb), .tx_axi(tx_axi), .ERR(err), .dbg_skid_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rx_mfb.src_rdy = 1'b0;
    rx_mfb.sof     = '0;
    rx_mfb.eof     = '0;
    rx_mfb.sof_pos = '0;
    rx_mfb.eof_pos = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DWIDTH-1:0] d, input logic [1:0] sof, input logic [1:0] eof,
                           input logic [1:0] sof_pos, input logic [5:0] eof_pos);
    int n;
    rx_mfb.data    = d;
    rx_mfb.sof     = sof;
    rx_mfb.eof     = eof;
    rx_mfb.sof_pos = sof_pos;
    rx_mfb.eof_pos = eof_pos;
    rx_mfb.src_rdy = 1'b1;
    n = 0;
    while (rx_mfb.dst_rdy !== 1'b1 && n < 50) begin cycle(); n++; end
    n_cmp++;
    if (n == 50) begin n_err++; $display("FAIL push_timeout: dst_rdy %b after 50 cycles, want 1", rx_mfb.dst_rdy); end
    else cycle();
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rx_mfb.data   = '0;
    tx_axi.tready = 1'b1;
    rst = 1'b1;
    #2;
    n_cmp++; if (tx_axi.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", tx_axi.tvalid); end
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b0) begin n_err++; $display("FAIL rst_dst_rdy: got %b want 0", rx_mfb.dst_rdy); end
    n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", err); end
    n_cmp++; if (int'(dbg_state) !== 0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", dbg_state); end
    cycle(); cycle();
    rst = 1'b0;
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rel_dst_rdy: got %b want 0", rx_mfb.dst_rdy); end
    cycle();
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_dst_rdy: got %b want 1", rx_mfb.dst_rdy); end
  endtask

  task automatic test_single_word();
    logic [DWIDTH-1:0] d;
    d = {16{32'hA1B2_0000}};
    tx_axi.tready  = 1'b1;
    rx_mfb.data    = d;
    rx_mfb.sof     = 2'b01;
    rx_mfb.eof     = 2'b01;
    rx_mfb.sof_pos = 2'b00;
    rx_mfb.eof_pos = 6'b000_011;
    rx_mfb.src_rdy = 1'b1;
    n_cmp++; if (tx_axi.tvalid !== 1'b0) begin n_err++; $display("FAIL t1_pre_tvalid: got %b want 0", tx_axi.tvalid); end
    cycle();
    drive_idle();
    n_cmp++; if (tx_axi.tvalid !== 1'b1) begin n_err++; $display("FAIL t1_tvalid: got %b want 1", tx_axi.tvalid); end
    n_cmp++; if (tx_axi.tdata !== d) begin n_err++; $display("FAIL t1_tdata: got %h want %h", tx_axi.tdata, d); end
    n_cmp++; if (tx_axi.tuser !== 12'h835) begin n_err++; $display("FAIL t1_tuser: got %h want 835", tx_axi.tuser); end
    n_cmp++; if (tx_axi.tkeep !== 16'h000F) begin n_err++; $display("FAIL t1_tkeep: got %h want 000f", tx_axi.tkeep); end
    n_cmp++; if (tx_axi.tlast !== 1'b1) begin n_err++; $display("FAIL t1_tlast: got %b want 1", tx_axi.tlast); end
    n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL t1_err: got %b want 00", err); end
    cycle();
    n_cmp++; if (tx_axi.tvalid !== 1'b0) begin n_err++; $display("FAIL t1_drained: got %b want 0", tx_axi.tvalid); end
  endtask

  task automatic test_straddle();
    logic [1:0]  sof_v[3]  = '{2'b10, 2'b10, 2'b00};
    logic [1:0]  eof_v[3]  = '{2'b00, 2'b01, 2'b10};
    logic [5:0]  epos_v[3] = '{6'b000_000, 6'b000_111, 6'b000_000};
    logic [15:0] keep_v[3] = '{16'hFF00, 16'hFFFF, 16'h01FF};
    logic        last_v[3] = '{1'b0, 1'b0, 1'b1};
    logic [11:0] user_v[3] = '{12'h802, 12'h876, 12'h808};
    tx_axi.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_beat({16{32'h5700_0000 + 32'(i)}}, sof_v[i], eof_v[i], 2'b00, epos_v[i]);
      n_cmp++; if (tx_axi.tkeep !== keep_v[i]) begin n_err++; $display("FAIL t2_tkeep[%0d]: got %h want %h", i, tx_axi.tkeep, keep_v[i]); end
      n_cmp++; if (tx_axi.tlast !== last_v[i]) begin n_err++; $display("FAIL t2_tlast[%0d]: got %b want %b", i, tx_axi.tlast, last_v[i]); end
      n_cmp++; if (tx_axi.tuser !== user_v[i]) begin n_err++; $display("FAIL t2_tuser[%0d]: got %h want %h", i, tx_axi.tuser, user_v[i]); end
    end
    n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL t2_err: got %b want 00", err); end
    cycle(); cycle();
  endtask

  task automatic test_back_to_back();
    logic [DWIDTH+DW:0] exp_q[$];
    logic [DWIDTH+DW:0] got, exp;
    logic [DW-1:0]      kexp;
    logic               lexp, acc, pop;
    int                 sent = 0, popped = 0, occ = 0, cyc = 0, pkt;
    bit                 saw_full = 0;
    while ((sent < 20 || popped < 20) && cyc < 400) begin
      tx_axi.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      kexp = 16'hFFFF;
      lexp = 1'b0;
      if (sent < 20) begin
        pkt = sent / 2;
        rx_mfb.data    = {16{32'h3000_0000 + 32'(sent)}};
        rx_mfb.sof_pos = 2'b00;
        rx_mfb.src_rdy = 1'b1;
        if (sent % 2 == 0) begin
          rx_mfb.sof = 2'b01; rx_mfb.eof = 2'b00; rx_mfb.eof_pos = '0;
        end else begin
          rx_mfb.sof = 2'b00; rx_mfb.eof = 2'b10; rx_mfb.eof_pos = {3'(pkt % 8), 3'd0};
          kexp = 16'h00FF | (16'((32'd2 << (pkt % 8)) - 1) << 8);
          lexp = 1'b1;
        end
      end else drive_idle();
      n_cmp++; if (rx_mfb.dst_rdy !== (occ < 2)) begin n_err++; $display("FAIL b2b_dst_rdy cyc %0d: got %b want %b", cyc, rx_mfb.dst_rdy, occ < 2); end
      n_cmp++; if (int'(dbg_state) !== occ) begin n_err++; $display("FAIL b2b_occ cyc %0d: got %0d want %0d", cyc, dbg_state, occ); end
      n_cmp++; if (tx_axi.tvalid !== (occ > 0)) begin n_err++; $display("FAIL b2b_tvalid cyc %0d: got %b want %b", cyc, tx_axi.tvalid, occ > 0); end
      acc = rx_mfb.src_rdy && rx_mfb.dst_rdy;
      pop = tx_axi.tvalid && tx_axi.tready;
      if (pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_word: got keep %h want none", tx_axi.tkeep); end
        else begin
          exp = exp_q.pop_front();
          got = {tx_axi.tdata, tx_axi.tkeep, tx_axi.tlast};
          if (got !== exp) begin n_err++; $display("FAIL b2b_word %0d: got %h want %h", popped, got[DW:0], exp[DW:0]); end
        end
        popped++;
      end
      if (acc) begin exp_q.push_back({rx_mfb.data, kexp, lexp}); sent++; end
      occ = occ + int'(acc) - int'(pop);
      if (occ == 2) saw_full = 1;
      cycle();
      cyc++;
    end
    drive_idle();
    tx_axi.tready = 1'b1;
    n_cmp++; if (popped !== 20 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d popped, %0d left, want 20, 0", popped, exp_q.size()); end
    n_cmp++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL b2b_full_seen: got %b want 1", saw_full); end
    cycle(); cycle();
  endtask

  task automatic test_errors();
    logic [1:0]  sof_v[5]  = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    logic [1:0]  spos_v[5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]  eof_v[5]  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [5:0]  epos_v[5] = '{6'b000_001, 6'b000_000, 6'b000_000, 6'b000_000, 6'b000_111};
    logic [15:0] keep_v[5] = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h00FF};
    logic        last_v[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  err_v[5]  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [DWIDTH-1:0] d;
    tx_axi.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = {16{32'hE440_0000 + 32'(i)}};
      push_beat(d, sof_v[i], eof_v[i], spos_v[i], epos_v[i]);
      n_cmp++; if (tx_axi.tdata !== d) begin n_err++; $display("FAIL t4_tdata[%0d]: got %h want %h", i, tx_axi.tdata[31:0], d[31:0]); end
      n_cmp++; if (tx_axi.tkeep !== keep_v[i]) begin n_err++; $display("FAIL t4_tkeep[%0d]: got %h want %h", i, tx_axi.tkeep, keep_v[i]); end
      n_cmp++; if (tx_axi.tlast !== last_v[i]) begin n_err++; $display("FAIL t4_tlast[%0d]: got %b want %b", i, tx_axi.tlast, last_v[i]); end
      n_cmp++; if (err !== err_v[i]) begin n_err++; $display("FAIL t4_err[%0d]: got %b want %b", i, err, err_v[i]); end
    end
    cycle(); cycle();
  endtask

  task automatic test_reset_mid_packet();
    tx_axi.tready = 1'b0;
    push_beat({16{32'h7700_0001}}, 2'b01, 2'b00, 2'b00, 6'b0);
    push_beat({16{32'h7700_0002}}, 2'b00, 2'b00, 2'b00, 6'b0);
    n_cmp++; if (int'(dbg_state) !== 2) begin n_err++; $display("FAIL t5_occ_full: got %0d want 2", dbg_state); end
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b0) begin n_err++; $display("FAIL t5_dst_rdy_full: got %b want 0", rx_mfb.dst_rdy); end
    n_cmp++; if (err !== 2'b11) begin n_err++; $display("FAIL t5_err_before: got %b want 11", err); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (tx_axi.tvalid !== 1'b0) begin n_err++; $display("FAIL t5_async_tvalid: got %b want 0", tx_axi.tvalid); end
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b0) begin n_err++; $display("FAIL t5_async_dst_rdy: got %b want 0", rx_mfb.dst_rdy); end
    n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL t5_err_cleared: got %b want 00", err); end
    cycle(); cycle();
    rst = 1'b0;
    tx_axi.tready = 1'b1;
    cycle();
    n_cmp++; if (rx_mfb.dst_rdy !== 1'b1) begin n_err++; $display("FAIL t5_dst_rdy_back: got %b want 1", rx_mfb.dst_rdy); end
    // continuation-looking beat must not be kept once in_pkt has been discarded
    push_beat({16{32'h7700_0003}}, 2'b00, 2'b00, 2'b00, 6'b0);
    n_cmp++; if (tx_axi.tkeep !== 16'h0000) begin n_err++; $display("FAIL t5_stale_tkeep: got %h want 0000", tx_axi.tkeep); end
    n_cmp++; if (tx_axi.tlast !== 1'b0) begin n_err++; $display("FAIL t5_stale_tlast: got %b want 0", tx_axi.tlast); end
    push_beat({16{32'h7700_0004}}, 2'b10, 2'b10, 2'b00, 6'b011_000);
    n_cmp++; if (tx_axi.tdata !== {16{32'h7700_0004}}) begin n_err++; $display("FAIL t5_new_tdata: got %h want %h", tx_axi.tdata[31:0], 32'h7700_0004); end
    n_cmp++; if (tx_axi.tkeep !== 16'h0F00) begin n_err++; $display("FAIL t5_new_tkeep: got %h want 0f00", tx_axi.tkeep); end
    n_cmp++; if (tx_axi.tuser !== 12'hB0A) begin n_err++; $display("FAIL t5_new_tuser: got %h want b0a", tx_axi.tuser); end
    n_cmp++; if (tx_axi.tlast !== 1'b1) begin n_err++; $display("FAIL t5_new_tlast: got %b want 1", tx_axi.tlast); end
    n_cmp++; if (err !== 2'b00) begin n_err++; $display("FAIL t5_new_err: got %b want 00", err); end
    push_beat({16{32'h7700_0005}}, 2'b00, 2'b01, 2'b00, 6'b0);
    n_cmp++; if (tx_axi.tuser !== 12'h804) begin n_err++; $display("FAIL t5_orphan_tuser: got %h want 804", tx_axi.tuser); end
    n_cmp++; if (tx_axi.tkeep !== 16'h0000) begin n_err++; $display("FAIL t5_orphan_tkeep: got %h want 0000", tx_axi.tkeep); end
    n_cmp++; if (err !== 2'b10) begin n_err++; $display("FAIL t5_orphan_err: got %b want 10", err); end
    cycle(); cycle();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_straddle();
    test_back_to_back();
    test_errors();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
